// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
// Shared types and default bus widths for the CPU memory-bus slice.
//   ADDR_W / DATA_W : default address and data widths of the memory bus
//   arb_state_t     : arbiter FSM states (idle, fetch granted, data granted)
//   requester_t     : identifies which requester owned the most recent grant
package mips_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

endpackage

// File: rtl/mips_bus_watchdog.sv
// mips_bus_watchdog
// Counts consecutive bus-stall cycles of one transaction and raises a sticky
// flag once the count reaches TIMEOUT. The count saturates and never wraps.
// Ports:
//   clk     : system clock
//   reset   : synchronous active-high reset (clears count and flag)
//   clear   : restart the count for a new transaction
//   stall   : one stalled bus cycle of the current transaction
//   timeout : sticky flag, set when the count reaches TIMEOUT
module mips_bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] count;

  // The flag is set on the same edge that moves the count onto LIMIT, so it
  // is visible right after the TIMEOUT-th stall cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      timeout <= 1'b0;
    end else if (clear) begin
      count <= '0;
    end else if (stall && (count != LIMIT)) begin
      count <= count + ONE;
      if (count == (LIMIT - ONE)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares one Avalon-style memory bus between the instruction-fetch port
// (i_*) and the data port (d_*) of the Harvard core. Round-robin between the
// two requesters, one idle bubble after every transaction, plus a stall
// watchdog. Data passes through unchanged.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   i_read/i_address: fetch request and address; i_waitrequest/i_readdata back
//   d_read/d_write/d_address/d_writedata/d_byteenable: data request and payload;
//                     d_waitrequest/d_readdata back
//   m_*             : shared memory bus
//   timeout         : sticky, a transaction stalled for TIMEOUT cycles
//   proto_err       : sticky, d_read and d_write were both high in IDLE
module mips_mem_arbiter #(
  parameter int ADDR_W  = mips_bus_pkg::ADDR_W,
  parameter int DATA_W  = mips_bus_pkg::DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                m_read,
  output logic                m_write,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  output logic                timeout,
  output logic                proto_err
);

  import mips_bus_pkg::*;

  arb_state_t state;
  arb_state_t next_state;
  requester_t last_gnt;

  logic d_req;
  logic wd_clear;
  logic wd_stall;

  assign d_req = d_read | d_write;

  // Read data is a plain copy of the bus; each port's handshake qualifies it.
  assign i_readdata = m_readdata;
  assign d_readdata = m_readdata;

  // Arbitration only happens in IDLE. A grant always ends in IDLE, so the
  // requester gets one cycle to drop or refresh its request.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_read && d_req) begin
          next_state = (last_gnt == REQ_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
          next_state = GNT_D;
        end else if (i_read) begin
          next_state = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (!m_waitrequest) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_gnt  <= REQ_I;
      proto_err <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == GNT_I) begin
        last_gnt <= REQ_I;
      end else if (state == IDLE && next_state == GNT_D) begin
        last_gnt <= REQ_D;
      end
      if (state == IDLE && d_read && d_write) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Bus strobes follow the owning port, so a port that drops its request
  // mid-grant also drops the strobe. A simultaneous read+write from the data
  // port is issued as a write only. Reset overrides strobes and ready paths
  // in the same cycle so an in-flight transaction is abandoned at once.
  always_comb begin
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_address     = '0;
    m_writedata   = '0;
    m_byteenable  = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    case (state)
      GNT_I: begin
        m_read        = i_read;
        m_address     = i_address;
        m_byteenable  = '1;
        i_waitrequest = m_waitrequest;
      end
      GNT_D: begin
        m_read        = d_read & ~d_write;
        m_write       = d_write;
        m_address     = d_address;
        m_writedata   = d_writedata;
        m_byteenable  = d_byteenable;
        d_waitrequest = m_waitrequest;
      end
      default: ;
    endcase
    if (reset) begin
      m_read        = 1'b0;
      m_write       = 1'b0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
    end
  end

  // IDLE always precedes a grant, so clearing there restarts the count on
  // entry to every transaction.
  assign wd_clear = (state == IDLE);
  assign wd_stall = (state != IDLE) && m_waitrequest;

  mips_bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .stall  (wd_stall),
    .timeout(timeout)
  );

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter
// Directed bench for mips_mem_arbiter with TIMEOUT=4. Each task drives one
// scenario and compares DUT outputs against hand-computed values.
module tb_mips_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_read;
  logic [31:0] i_address;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_address;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        timeout;
  logic        proto_err;

  int total;
  int bad;

  mips_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_waitrequest(i_waitrequest),
    .i_readdata   (i_readdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_byteenable (d_byteenable),
    .d_waitrequest(d_waitrequest),
    .d_readdata   (d_readdata),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_byteenable (m_byteenable),
    .m_waitrequest(m_waitrequest),
    .m_readdata   (m_readdata),
    .timeout      (timeout),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL sim_time_limit: got still running want finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read        = 1'b0;
    i_address     = 32'h0;
    d_read        = 1'b0;
    d_write       = 1'b0;
    d_address     = 32'h0;
    d_writedata   = 32'h0;
    d_byteenable  = 4'h0;
    m_waitrequest = 1'b0;
    m_readdata    = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++; if (m_read !== 1'b0) begin bad++; $display("[TB] FAIL rst_m_read: got %b want 0", m_read); end
    total++; if (m_write !== 1'b0) begin bad++; $display("[TB] FAIL rst_m_write: got %b want 0", m_write); end
    total++; if (i_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rst_i_wait: got %b want 1", i_waitrequest); end
    total++; if (d_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rst_d_wait: got %b want 1", d_waitrequest); end
    total++; if (m_byteenable !== 4'h0) begin bad++; $display("[TB] FAIL rst_m_be: got %h want 0", m_byteenable); end
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL rst_timeout: got %b want 0", timeout); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_proto_err: got %b want 0", proto_err); end
  endtask

  task automatic test_single_fetch();
    i_read        = 1'b1;
    i_address     = 32'hBFC00000;
    m_waitrequest = 1'b0;
    m_readdata    = 32'h12345678;
    #1;
    total++; if (i_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL fetch_idle_wait: got %b want 1", i_waitrequest); end
    total++; if (m_read !== 1'b0) begin bad++; $display("[TB] FAIL fetch_idle_m_read: got %b want 0", m_read); end
    tick();
    total++; if (m_read !== 1'b1) begin bad++; $display("[TB] FAIL fetch_m_read: got %b want 1", m_read); end
    total++; if (m_write !== 1'b0) begin bad++; $display("[TB] FAIL fetch_m_write: got %b want 0", m_write); end
    total++; if (m_address !== 32'hBFC00000) begin bad++; $display("[TB] FAIL fetch_m_addr: got %h want bfc00000", m_address); end
    total++; if (m_byteenable !== 4'hF) begin bad++; $display("[TB] FAIL fetch_m_be: got %h want f", m_byteenable); end
    total++; if (i_waitrequest !== 1'b0) begin bad++; $display("[TB] FAIL fetch_i_wait: got %b want 0", i_waitrequest); end
    total++; if (d_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL fetch_d_wait: got %b want 1", d_waitrequest); end
    total++; if (i_readdata !== 32'h12345678) begin bad++; $display("[TB] FAIL fetch_rdata: got %h want 12345678", i_readdata); end
    tick();
    i_read = 1'b0;
    #1;
    total++; if (m_read !== 1'b0) begin bad++; $display("[TB] FAIL fetch_after_m_read: got %b want 0", m_read); end
    total++; if (i_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL fetch_after_i_wait: got %b want 1", i_waitrequest); end
  endtask

  task automatic test_protocol_error();
    d_read        = 1'b1;
    d_write       = 1'b1;
    d_address     = 32'h00003000;
    d_writedata   = 32'h0BADF00D;
    d_byteenable  = 4'hF;
    m_waitrequest = 1'b0;
    #1;
    total++; if (proto_err !== 1'b0) begin bad++; $display("[TB] FAIL perr_before: got %b want 0", proto_err); end
    tick();
    total++; if (m_write !== 1'b1) begin bad++; $display("[TB] FAIL perr_m_write: got %b want 1", m_write); end
    total++; if (m_read !== 1'b0) begin bad++; $display("[TB] FAIL perr_m_read: got %b want 0", m_read); end
    total++; if (m_address !== 32'h00003000) begin bad++; $display("[TB] FAIL perr_m_addr: got %h want 00003000", m_address); end
    total++; if (m_writedata !== 32'h0BADF00D) begin bad++; $display("[TB] FAIL perr_m_wdata: got %h want 0badf00d", m_writedata); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("[TB] FAIL perr_set: got %b want 1", proto_err); end
    tick();
    d_read  = 1'b0;
    d_write = 1'b0;
    #1;
    tick();
    tick();
    total++; if (proto_err !== 1'b1) begin bad++; $display("[TB] FAIL perr_sticky: got %b want 1", proto_err); end
  endtask

  task automatic test_contention();
    do_reset();
    total++; if (proto_err !== 1'b0) begin bad++; $display("[TB] FAIL cont_perr_cleared: got %b want 0", proto_err); end
    i_read        = 1'b1;
    i_address     = 32'h00000400;
    d_write       = 1'b1;
    d_address     = 32'h00001000;
    d_writedata   = 32'hCAFEF00D;
    d_byteenable  = 4'h3;
    m_waitrequest = 1'b0;
    for (int p = 0; p < 4; p++) begin
      tick();
      total++; if (m_write !== 1'b1) begin bad++; $display("[TB] FAIL cont_d_m_write[%0d]: got %b want 1", p, m_write); end
      total++; if (m_read !== 1'b0) begin bad++; $display("[TB] FAIL cont_d_m_read[%0d]: got %b want 0", p, m_read); end
      total++; if (m_address !== 32'h00001000) begin bad++; $display("[TB] FAIL cont_d_addr[%0d]: got %h want 00001000", p, m_address); end
      total++; if (m_byteenable !== 4'h3) begin bad++; $display("[TB] FAIL cont_d_be[%0d]: got %h want 3", p, m_byteenable); end
      total++; if (m_writedata !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL cont_d_wdata[%0d]: got %h want cafef00d", p, m_writedata); end
      total++; if (i_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL cont_d_i_wait[%0d]: got %b want 1", p, i_waitrequest); end
      total++; if (d_waitrequest !== 1'b0) begin bad++; $display("[TB] FAIL cont_d_d_wait[%0d]: got %b want 0", p, d_waitrequest); end
      tick();
      total++; if ((m_read | m_write) !== 1'b0) begin bad++; $display("[TB] FAIL cont_bubble1[%0d]: got %b want 0", p, m_read | m_write); end
      tick();
      total++; if (m_read !== 1'b1) begin bad++; $display("[TB] FAIL cont_i_m_read[%0d]: got %b want 1", p, m_read); end
      total++; if (m_write !== 1'b0) begin bad++; $display("[TB] FAIL cont_i_m_write[%0d]: got %b want 0", p, m_write); end
      total++; if (m_address !== 32'h00000400) begin bad++; $display("[TB] FAIL cont_i_addr[%0d]: got %h want 00000400", p, m_address); end
      total++; if (m_byteenable !== 4'hF) begin bad++; $display("[TB] FAIL cont_i_be[%0d]: got %h want f", p, m_byteenable); end
      total++; if (i_waitrequest !== 1'b0) begin bad++; $display("[TB] FAIL cont_i_i_wait[%0d]: got %b want 0", p, i_waitrequest); end
      total++; if (d_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL cont_i_d_wait[%0d]: got %b want 1", p, d_waitrequest); end
      if (p == 3) begin
        i_read  = 1'b0;
        d_write = 1'b0;
      end
      tick();
      total++; if ((m_read | m_write) !== 1'b0) begin bad++; $display("[TB] FAIL cont_bubble2[%0d]: got %b want 0", p, m_read | m_write); end
    end
  endtask

  task automatic test_bus_stall();
    d_read        = 1'b1;
    d_address     = 32'h00002000;
    i_read        = 1'b1;
    i_address     = 32'h00000500;
    m_waitrequest = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      total++; if (d_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL stall_d_wait[%0d]: got %b want 1", k, d_waitrequest); end
      total++; if (i_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL stall_i_wait[%0d]: got %b want 1", k, i_waitrequest); end
      total++; if (m_read !== 1'b1) begin bad++; $display("[TB] FAIL stall_m_read[%0d]: got %b want 1", k, m_read); end
      total++; if (m_address !== 32'h00002000) begin bad++; $display("[TB] FAIL stall_addr[%0d]: got %h want 00002000", k, m_address); end
      tick();
    end
    m_waitrequest = 1'b0;
    m_readdata    = 32'hDEADBEEF;
    #1;
    total++; if (d_waitrequest !== 1'b0) begin bad++; $display("[TB] FAIL stall_done_d_wait: got %b want 0", d_waitrequest); end
    total++; if (d_readdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL stall_done_rdata: got %h want deadbeef", d_readdata); end
    total++; if (i_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL stall_done_i_wait: got %b want 1", i_waitrequest); end
    tick();
    d_read = 1'b0;
    #1;
    total++; if (m_read !== 1'b0) begin bad++; $display("[TB] FAIL stall_bubble: got %b want 0", m_read); end
    tick();
    m_readdata = 32'h00C0FFEE;
    #1;
    total++; if (m_address !== 32'h00000500) begin bad++; $display("[TB] FAIL stall_fetch_addr: got %h want 00000500", m_address); end
    total++; if (i_waitrequest !== 1'b0) begin bad++; $display("[TB] FAIL stall_fetch_i_wait: got %b want 0", i_waitrequest); end
    total++; if (i_readdata !== 32'h00C0FFEE) begin bad++; $display("[TB] FAIL stall_fetch_rdata: got %h want 00c0ffee", i_readdata); end
    tick();
    i_read = 1'b0;
    #1;
  endtask

  task automatic test_timeout();
    logic exp_to;
    do_reset();
    i_read        = 1'b1;
    i_address     = 32'h00000600;
    m_waitrequest = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_to = (k >= 4);
      total++; if (timeout !== exp_to) begin bad++; $display("[TB] FAIL to_flag[%0d]: got %b want %b", k, timeout, exp_to); end
      total++; if (i_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL to_i_wait[%0d]: got %b want 1", k, i_waitrequest); end
      tick();
    end
    m_waitrequest = 1'b0;
    #1;
    total++; if (i_waitrequest !== 1'b0) begin bad++; $display("[TB] FAIL to_complete: got %b want 0", i_waitrequest); end
    tick();
    i_read = 1'b0;
    #1;
    tick();
    total++; if (timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky: got %b want 1", timeout); end
    do_reset();
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_cleared: got %b want 0", timeout); end
  endtask

  task automatic test_reset_mid();
    i_read        = 1'b1;
    i_address     = 32'h00000700;
    m_waitrequest = 1'b1;
    tick();
    total++; if (m_read !== 1'b1) begin bad++; $display("[TB] FAIL rmid_m_read_before: got %b want 1", m_read); end
    reset        = 1'b1;
    d_write      = 1'b1;
    d_address    = 32'h00001000;
    d_writedata  = 32'h11223344;
    d_byteenable = 4'hC;
    #1;
    total++; if (m_read !== 1'b0) begin bad++; $display("[TB] FAIL rmid_m_read_forced: got %b want 0", m_read); end
    total++; if (i_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rmid_i_wait_forced: got %b want 1", i_waitrequest); end
    total++; if (d_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rmid_d_wait_forced: got %b want 1", d_waitrequest); end
    tick();
    reset         = 1'b0;
    m_waitrequest = 1'b0;
    #1;
    total++; if ((m_read | m_write) !== 1'b0) begin bad++; $display("[TB] FAIL rmid_idle: got %b want 0", m_read | m_write); end
    tick();
    total++; if (m_write !== 1'b1) begin bad++; $display("[TB] FAIL rmid_d_first_write: got %b want 1", m_write); end
    total++; if (m_byteenable !== 4'hC) begin bad++; $display("[TB] FAIL rmid_d_first_be: got %h want c", m_byteenable); end
    total++; if (d_waitrequest !== 1'b0) begin bad++; $display("[TB] FAIL rmid_d_first_wait: got %b want 0", d_waitrequest); end
    total++; if (i_waitrequest !== 1'b1) begin bad++; $display("[TB] FAIL rmid_i_held: got %b want 1", i_waitrequest); end
    tick();
    idle_inputs();
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_fetch();
    test_protocol_error();
    test_contention();
    test_bus_stall();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one Avalon-style memory bus between the CPU instruction-fetch port and data port.
- Used by the bus-variant CPU wrapper: the Harvard core's instr_* and data_* ports connect to its two requester sides, and the single memory bus connects to its bus side.
- Two-requester round-robin arbitration over a 3-state FSM, plus a bus-stall watchdog counter.
- Data passes through unchanged; endianness is the core's concern.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports; byteenable width is DATA_W/8.
- TIMEOUT, 255, number of consecutive bus waitrequest cycles in one transaction before the timeout flag sets; range 1..65535.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_read  in  1  instruction fetch request (read only).
- i_address  in  ADDR_W  fetch address.
- i_waitrequest  out  1  stall to fetch port.
- i_readdata  out  DATA_W  fetch data; valid when i_read=1 and i_waitrequest=0.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_address  in  ADDR_W  data address.
- d_writedata  in  DATA_W  store data.
- d_byteenable  in  DATA_W/8  store byte lanes.
- d_waitrequest  out  1  stall to data port.
- d_readdata  out  DATA_W  load data; valid when d_read=1 and d_waitrequest=0.
- m_read  out  1  bus read.
- m_write  out  1  bus write.
- m_address  out  ADDR_W  bus address.
- m_writedata  out  DATA_W  bus write data.
- m_byteenable  out  DATA_W/8  bus byte lanes; all ones for fetch.
- m_waitrequest  in  1  bus stall.
- m_readdata  in  DATA_W  bus read data.
- timeout  out  1  sticky: a transaction exceeded TIMEOUT stall cycles.
- proto_err  out  1  sticky: d_read and d_write were both high in IDLE.

Behaviour:
- Requesters follow the Avalon hold rule: request and payload stay stable while their waitrequest=1.
- FSM states are IDLE, GNT_I and GNT_D.
- IDLE:
  - m_read=m_write=0, m_byteenable=0, m_address=0, i_waitrequest=d_waitrequest=1.
  - Arbitration is registered. If exactly one port requests, go to its GNT state next cycle.
  - If both request, grant the port not granted last: last_gnt register, reset value = I, so data wins first after reset. Update last_gnt on every grant.
- GNT_I: m_read=1, m_address=i_address, m_byteenable all ones, m_writedata=0. d_waitrequest=1, i_waitrequest=m_waitrequest.
- GNT_D: m_read=d_read, m_write=d_write, address, writedata and byteenable from the d port. i_waitrequest=1, d_waitrequest=m_waitrequest.
- Completion = GNT state and m_waitrequest=0. The next state is always IDLE, so there is one idle bubble and the requester is guaranteed to drop or refresh its request.
- Minimum transaction: request seen at cycle t, bus strobe at t+1, completion at t+1, IDLE at t+2.
- i_readdata and d_readdata are combinational copies of m_readdata, always driven. Validity is defined by each port's own handshake.
- Requester drops its request in GNT state (protocol violation):
  - Bus strobes follow the port, so they go low.
  - The FSM stays in GNT until m_waitrequest=0 is seen. If the bus has nothing to acknowledge, the watchdog counter keeps running.
- Both d_read and d_write high in IDLE:
  - Grant as a write with m_read forced 0, and set proto_err.
  - proto_err clears only on reset.
- Watchdog:
  - The stall counter clears on entry to any GNT state.
  - It increments each GNT cycle with m_waitrequest=1 and saturates at TIMEOUT.
  - When it reaches TIMEOUT, set timeout (sticky until reset). The transaction keeps waiting and is not aborted.
- Reset (synchronous):
  - Resets FSM to IDLE, last_gnt=I, counter=0, timeout=0, proto_err=0.
  - During any cycle with reset=1, m_read, m_write and both requester-ready paths are forced to their inactive values combinationally, even mid-transaction.
  - The in-flight bus transaction is abandoned; the memory model must tolerate this.
- Both requests present on the same cycle a completion occurs: no effect. The completion cycle goes to IDLE, and arbitration happens there.

Decomposition:
- Shared package mips_bus_pkg:
  - arb_state_t enum {IDLE, GNT_I, GNT_D}.
  - requester enum {REQ_I, REQ_D}.
  - Bus width constants ADDR_W and DATA_W.
- One natural sub-module: mips_bus_watchdog (saturating counter plus sticky flag; inputs clear, stall, reset).

Test Plan:
- Single fetch: reset, i_read=1, i_address=0xBFC00000, bus waitrequest=0, readdata=0x12345678 -> m_read=1 at t+1 with m_address=0xBFC00000 and byteenable=0xF; i_waitrequest=0 at t+1; i_readdata=0x12345678; FSM IDLE at t+2.
- Contention: both ports request from reset, d_write=1, d_address=0x1000, d_writedata=0xCAFEF00D, byteenable=0x3 -> data is granted first with m_write=1 and byteenable=0x3; fetch is granted next after one IDLE bubble; then alternation continues over 4 back-to-back pairs.
- Bus stall: m_waitrequest held 5 cycles during GNT_D read -> d_waitrequest=1 for 5 cycles, then 0 with d_readdata valid; fetch port waitrequest=1 throughout.
- Timeout: TIMEOUT=4, m_waitrequest stuck high -> timeout=1 after exactly 4 stall cycles; it stays 1 after a later completion and clears only on reset.
- Reset mid-transaction: assert reset during GNT_I with m_waitrequest=1 -> m_read=0 in that same cycle; IDLE next; a subsequent dual request grants data first.
- Protocol error: d_read=d_write=1 in IDLE -> write issued with m_read=0; proto_err=1 and sticky.
